// File: rtl/cpu_param.sv
// ----------------------------------------------------------------------------
// cpu_param : shared constants for the P6 five-stage MIPS pipeline.
//   - ALU_* : alu_op encodings consumed by the execute stage
//   - MD_*  : md_op encodings for the multiply/divide unit
//   - FWD_* : operand forwarding mux selects
//   - PC_RESET, INSTR_NOP, FWD_DEBUG_WORD : reset / debug constants
//   - timer_dec() : saturating decrement shared by the hazard timers
// No ports (package).
// ----------------------------------------------------------------------------
package cpu_param;

  localparam logic [4:0] ALU_ADDU = 5'd0;
  localparam logic [4:0] ALU_SUBU = 5'd1;
  localparam logic [4:0] ALU_AND  = 5'd2;
  localparam logic [4:0] ALU_OR   = 5'd3;
  localparam logic [4:0] ALU_XOR  = 5'd4;
  localparam logic [4:0] ALU_NOR  = 5'd5;
  localparam logic [4:0] ALU_SLT  = 5'd6;
  localparam logic [4:0] ALU_SLTU = 5'd7;
  localparam logic [4:0] ALU_SLL  = 5'd8;
  localparam logic [4:0] ALU_SRL  = 5'd9;
  localparam logic [4:0] ALU_SRA  = 5'd10;
  localparam logic [4:0] ALU_SLLV = 5'd11;
  localparam logic [4:0] ALU_SRLV = 5'd12;
  localparam logic [4:0] ALU_SRAV = 5'd13;
  localparam logic [4:0] ALU_LUI  = 5'd14;
  localparam logic [4:0] ALU_MFHI = 5'd15;
  localparam logic [4:0] ALU_MFLO = 5'd16;
  localparam logic [4:0] ALU_LINK = 5'd17;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;
  localparam logic [1:0] FWD_DBG = 2'd3;

  localparam logic [31:0] PC_RESET       = 32'h0000_3000;
  // One-hot instruction type; bit 0 is sll, which encodes the canonical nop.
  localparam logic [59:0] INSTR_NOP      = 60'h1;
  localparam logic [31:0] FWD_DEBUG_WORD = 32'h1234_ABCD;

  // MDU FSM state codes.
  localparam logic [0:0] MDU_IDLE = 1'b0;
  localparam logic [0:0] MDU_BUSY = 1'b1;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

  function automatic logic [2:0] timer_dec(input logic [2:0] t);
    return (t == 3'd0) ? 3'd0 : t - 3'd1;
  endfunction

endpackage

// File: rtl/ex_mdu.sv
// ----------------------------------------------------------------------------
// ex_mdu : multi-cycle multiply/divide unit with HI/LO registers.
// The result is computed at issue and parked in a staging register; HI/LO
// take it on the edge where the busy counter steps from 1 to 0, which models
// the latency of a real iterative unit.
// Built only when EX_MDU_EN is defined; otherwise HI/LO read 0, busy is 0 and
// no flops are created.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   md_op_i      MDU function (MD_* codes)
//   a_i, b_i     forwarded rs / rt operands
//   hi_o, lo_o   architectural HI / LO
//   md_busy_o    MDU op starting this cycle, or counter nonzero
// ----------------------------------------------------------------------------
module ex_mdu
  import cpu_param::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  md_op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        md_busy_o
);

`ifdef EX_MDU_EN

  logic [0:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        stage_wr_q, stage_wr_d;
  hilo_t       stage_q, stage_d;

  logic        is_mul, is_div, start;
  logic        b_zero;
  logic signed [63:0] a_sx, b_sx, prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] a_s, b_s, quot_s, rem_s;
  logic        [31:0] b_nz, quot_u, rem_u;

  assign is_mul = (md_op_i == MD_MULT) || (md_op_i == MD_MULTU);
  assign is_div = (md_op_i == MD_DIV)  || (md_op_i == MD_DIVU);
  // Ops arriving while BUSY are dropped; the hazard unit should have stalled them.
  assign start  = (state_q == MDU_IDLE) && (is_mul || is_div);
  assign b_zero = (b_i == 32'd0);

  assign a_sx   = {{32{a_i[31]}}, a_i};
  assign b_sx   = {{32{b_i[31]}}, b_i};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, a_i} * {32'd0, b_i};

  // Divisor 0 is replaced by 1 only to keep the divider defined; the result is
  // discarded via stage_wr.
  assign b_nz   = b_zero ? 32'd1 : b_i;
  assign a_s    = a_i;
  assign b_s    = b_nz;
  // Signed / and % truncate toward zero, so the remainder follows the dividend.
  assign quot_s = a_s / b_s;
  assign rem_s  = a_s % b_s;
  assign quot_u = a_i / b_nz;
  assign rem_u  = a_i % b_nz;

  always_comb begin
    stage_d = stage_q;
    if (start) begin
      unique case (md_op_i)
        MD_MULT:  stage_d = hilo_t'(prod_s);
        MD_MULTU: stage_d = hilo_t'(prod_u);
        MD_DIV:   stage_d = '{hi: rem_s, lo: quot_s};
        default:  stage_d = '{hi: rem_u, lo: quot_u};
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    stage_wr_d = stage_wr_q;
    if (state_q == MDU_IDLE) begin
      if (start) begin
        state_d    = MDU_BUSY;
        cnt_d      = is_mul ? 8'(MULT_CYCLES) : 8'(DIV_CYCLES);
        stage_wr_d = is_mul || !b_zero;
      end else if (md_op_i == MD_MTHI) begin
        hi_d = a_i;
      end else if (md_op_i == MD_MTLO) begin
        lo_d = a_i;
      end
    end else begin
      cnt_d = cnt_q - 8'd1;
      if (cnt_q == 8'd1) begin
        state_d = MDU_IDLE;
        if (stage_wr_q) begin
          hi_d = stage_q.hi;
          lo_d = stage_q.lo;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= MDU_IDLE;
      cnt_q      <= 8'd0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      stage_wr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      stage_wr_q <= stage_wr_d;
    end
  end

  // Staging data needs no reset: it is only consumed when stage_wr_q is set.
  always_ff @(posedge clk) begin
    stage_q <= stage_d;
  end

  assign hi_o      = hi_q;
  assign lo_o      = lo_q;
  assign md_busy_o = start || (cnt_q != 8'd0);

`else

  logic md_unused;
  assign md_unused = ^{clk, reset, md_op_i, a_i, b_i,
                       32'(MULT_CYCLES), 32'(DIV_CYCLES)};

  assign hi_o      = 32'd0;
  assign lo_o      = 32'd0;
  assign md_busy_o = 1'b0;

`endif

endmodule

// File: rtl/ex_stage.sv
// ----------------------------------------------------------------------------
// ex_stage : execute stage of the P6 five-stage MIPS pipeline.
// Selects forwarded operands, runs the single-cycle ALU, drives the MDU and
// owns the EX/Mem pipeline register. Hazard bookkeeping (register numbers and
// decremented timers) is exported both combinationally and registered.
// Optional feature macro: EX_MDU_EN (MDU, HI/LO, md_busy); when undefined
// md_op is ignored, md_busy is 0 and mfhi/mflo return 0.
// Ports:
//   clk, reset                         clock, sync active-high reset
//   pc_in, instr_type_in               from ID/EX
//   rs_data, rt_data, imm32, shamt     operands from ID/EX
//   alu_op, md_op, b_sel               function selects
//   raddr0/1_in, waddr_in, tuse0/1_in, tnew_in   hazard info from ID/EX
//   fwd_sel0/1, bypass_mem, bypass_wb  forwarding controls and values
//   alu_out, dm_wdata, pc_out, instr_type_out, raddr*/waddr_out, t*_out
//                                      EX/Mem register outputs
//   raddr*_ex, waddr_ex, t*_ex         combinational hazard copies
//   md_busy                            MDU busy / starting
// ----------------------------------------------------------------------------
module ex_stage
  import cpu_param::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic [59:0] instr_type_in,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [31:0] imm32,
  input  logic [4:0]  shamt,
  input  logic [4:0]  alu_op,
  input  logic [2:0]  md_op,
  input  logic        b_sel,
  input  logic [4:0]  raddr0_in,
  input  logic [4:0]  raddr1_in,
  input  logic [4:0]  waddr_in,
  input  logic [2:0]  tuse0_in,
  input  logic [2:0]  tuse1_in,
  input  logic [2:0]  tnew_in,
  input  logic [1:0]  fwd_sel0,
  input  logic [1:0]  fwd_sel1,
  input  logic [31:0] bypass_mem,
  input  logic [31:0] bypass_wb,
  output logic [31:0] alu_out,
  output logic [31:0] dm_wdata,
  output logic [31:0] pc_out,
  output logic [59:0] instr_type_out,
  output logic [4:0]  raddr0_out,
  output logic [4:0]  raddr1_out,
  output logic [4:0]  waddr_out,
  output logic [2:0]  tuse0_out,
  output logic [2:0]  tuse1_out,
  output logic [2:0]  tnew_out,
  output logic [4:0]  raddr0_ex,
  output logic [4:0]  raddr1_ex,
  output logic [4:0]  waddr_ex,
  output logic [2:0]  tuse0_ex,
  output logic [2:0]  tuse1_ex,
  output logic [2:0]  tnew_ex,
  output logic        md_busy
);

  function automatic logic [31:0] fwd_pick(input logic [1:0]  sel,
                                           input logic [31:0] rf,
                                           input logic [31:0] mem,
                                           input logic [31:0] wb);
    unique case (sel)
      FWD_RF:  return rf;
      FWD_MEM: return mem;
      FWD_WB:  return wb;
      default: return FWD_DEBUG_WORD;
    endcase
  endfunction

  // Fixed shifts act on rt (MIPS semantics), variable shifts use A[4:0].
  function automatic logic [31:0] alu_calc(input logic [4:0]  op,
                                           input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [31:0] rt,
                                           input logic [4:0]  sa,
                                           input logic [31:0] pc,
                                           input logic [31:0] hi,
                                           input logic [31:0] lo);
    logic signed [31:0] a_s, b_s, rt_s;
    a_s  = a;
    b_s  = b;
    rt_s = rt;
    unique case (op)
      ALU_ADDU: return a + b;
      ALU_SUBU: return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_NOR:  return ~(a | b);
      ALU_SLT:  return {31'd0, (a_s < b_s)};
      ALU_SLTU: return {31'd0, (a < b)};
      ALU_SLL:  return rt << sa;
      ALU_SRL:  return rt >> sa;
      ALU_SRA:  return rt_s >>> sa;
      ALU_SLLV: return rt << a[4:0];
      ALU_SRLV: return rt >> a[4:0];
      ALU_SRAV: return rt_s >>> a[4:0];
      ALU_LUI:  return b << 16;
      ALU_MFHI: return hi;
      ALU_MFLO: return lo;
      ALU_LINK: return pc + 32'd8;
      default:  return 32'd0;
    endcase
  endfunction

  logic [31:0] rs_fwd, rt_fwd, op_b;
  logic [31:0] hi, lo;
  logic [31:0] alu_d;

  assign rs_fwd = fwd_pick(fwd_sel0, rs_data, bypass_mem, bypass_wb);
  assign rt_fwd = fwd_pick(fwd_sel1, rt_data, bypass_mem, bypass_wb);
  assign op_b   = b_sel ? imm32 : rt_fwd;

  ex_mdu #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_mdu (
    .clk       (clk),
    .reset     (reset),
    .md_op_i   (md_op),
    .a_i       (rs_fwd),
    .b_i       (rt_fwd),
    .hi_o      (hi),
    .lo_o      (lo),
    .md_busy_o (md_busy)
  );

  assign alu_d = alu_calc(alu_op, rs_fwd, op_b, rt_fwd, shamt, pc_in, hi, lo);

  assign raddr0_ex = raddr0_in;
  assign raddr1_ex = raddr1_in;
  assign waddr_ex  = waddr_in;
  assign tuse0_ex  = timer_dec(tuse0_in);
  assign tuse1_ex  = timer_dec(tuse1_in);
  assign tnew_ex   = timer_dec(tnew_in);

  // ---- EX/Mem pipeline register ----
  logic [31:0] alu_q, wdata_q, pc_q;
  logic [59:0] itype_q;
  logic [4:0]  ra0_q, ra1_q, wa_q;
  logic [2:0]  tu0_q, tu1_q, tn_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_q   <= 32'd0;
      wdata_q <= 32'd0;
      pc_q    <= PC_RESET;
      itype_q <= INSTR_NOP;
      ra0_q   <= 5'd0;
      ra1_q   <= 5'd0;
      wa_q    <= 5'd0;
      tu0_q   <= 3'b111;
      tu1_q   <= 3'b111;
      tn_q    <= 3'd0;
    end else begin
      alu_q   <= alu_d;
      wdata_q <= rt_fwd;
      pc_q    <= pc_in;
      itype_q <= instr_type_in;
      ra0_q   <= raddr0_in;
      ra1_q   <= raddr1_in;
      wa_q    <= waddr_in;
      tu0_q   <= tuse0_ex;
      tu1_q   <= tuse1_ex;
      tn_q    <= tnew_ex;
    end
  end

  assign alu_out        = alu_q;
  assign dm_wdata       = wdata_q;
  assign pc_out         = pc_q;
  assign instr_type_out = itype_q;
  assign raddr0_out     = ra0_q;
  assign raddr1_out     = ra1_q;
  assign waddr_out      = wa_q;
  assign tuse0_out      = tu0_q;
  assign tuse1_out      = tu1_q;
  assign tnew_out       = tn_q;

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;
  import cpu_param::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in;
  logic [59:0] instr_type_in;
  logic [31:0] rs_data, rt_data, imm32;
  logic [4:0]  shamt, alu_op;
  logic [2:0]  md_op;
  logic        b_sel;
  logic [4:0]  raddr0_in, raddr1_in, waddr_in;
  logic [2:0]  tuse0_in, tuse1_in, tnew_in;
  logic [1:0]  fwd_sel0, fwd_sel1;
  logic [31:0] bypass_mem, bypass_wb;
  logic [31:0] alu_out, dm_wdata, pc_out;
  logic [59:0] instr_type_out;
  logic [4:0]  raddr0_out, raddr1_out, waddr_out;
  logic [2:0]  tuse0_out, tuse1_out, tnew_out;
  logic [4:0]  raddr0_ex, raddr1_ex, waddr_ex;
  logic [2:0]  tuse0_ex, tuse1_ex, tnew_ex;
  logic        md_busy;

  int n_vec = 0;
  int n_bad = 0;

  ex_stage #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .instr_type_in(instr_type_in),
    .rs_data(rs_data), .rt_data(rt_data), .imm32(imm32), .shamt(shamt),
    .alu_op(alu_op), .md_op(md_op), .b_sel(b_sel),
    .raddr0_in(raddr0_in), .raddr1_in(raddr1_in), .waddr_in(waddr_in),
    .tuse0_in(tuse0_in), .tuse1_in(tuse1_in), .tnew_in(tnew_in),
    .fwd_sel0(fwd_sel0), .fwd_sel1(fwd_sel1),
    .bypass_mem(bypass_mem), .bypass_wb(bypass_wb),
    .alu_out(alu_out), .dm_wdata(dm_wdata), .pc_out(pc_out),
    .instr_type_out(instr_type_out),
    .raddr0_out(raddr0_out), .raddr1_out(raddr1_out), .waddr_out(waddr_out),
    .tuse0_out(tuse0_out), .tuse1_out(tuse1_out), .tnew_out(tnew_out),
    .raddr0_ex(raddr0_ex), .raddr1_ex(raddr1_ex), .waddr_ex(waddr_ex),
    .tuse0_ex(tuse0_ex), .tuse1_ex(tuse1_ex), .tnew_ex(tnew_ex),
    .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    pc_in = 32'h0000_3000; instr_type_in = INSTR_NOP;
    rs_data = 0; rt_data = 0; imm32 = 0; shamt = 0;
    alu_op = ALU_SLL; md_op = MD_NONE; b_sel = 0;
    raddr0_in = 0; raddr1_in = 0; waddr_in = 0;
    tuse0_in = 0; tuse1_in = 0; tnew_in = 0;
    fwd_sel0 = FWD_RF; fwd_sel1 = FWD_RF;
    bypass_mem = 0; bypass_wb = 0;
  endtask

  task automatic alu2(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    idle_in();
    alu_op = op; rs_data = a; rt_data = b;
  endtask

  initial begin
    reset = 1'b1;
    idle_in();
    step(); step();
    chk("rst_pc",    pc_out, 32'h0000_3000);
    chk("rst_tnew",  tnew_out, 0);
    chk("rst_tuse0", tuse0_out, 3'd7);
    chk("rst_tuse1", tuse1_out, 3'd7);
    chk("rst_busy",  md_busy, 0);
    chk("rst_alu",   alu_out, 0);
    chk("rst_itype", instr_type_out, 60'h1);
    chk("rst_wdata", dm_wdata, 0);
    reset = 1'b0;

    // addu with rs forwarded from Mem
    alu2(ALU_ADDU, 32'h7FFF_FFFF, 32'd1);
    fwd_sel0 = FWD_MEM; bypass_mem = 32'd5; tnew_in = 3'd2; waddr_in = 5'd3;
    pc_in = 32'h0000_3004; instr_type_in = 60'h4; tuse0_in = 3'd0; tuse1_in = 3'd5;
    raddr0_in = 5'd9; raddr1_in = 5'd10;
    #1;
    chk("tnew_ex",  tnew_ex, 3'd1);
    chk("waddr_ex", waddr_ex, 5'd3);
    chk("ra0_ex",   raddr0_ex, 5'd9);
    chk("tuse0_ex", tuse0_ex, 3'd0);
    step();
    chk("addu_fwd",   alu_out, 32'd6);
    chk("tnew_out",   tnew_out, 3'd1);
    chk("tuse0_sat",  tuse0_out, 3'd0);
    chk("tuse1_out",  tuse1_out, 3'd4);
    chk("pc_out",     pc_out, 32'h0000_3004);
    chk("itype_out",  instr_type_out, 60'h4);
    chk("waddr_out",  waddr_out, 5'd3);
    chk("ra1_out",    raddr1_out, 5'd10);
    chk("wdata_rt",   dm_wdata, 32'd1);

    // addu overflow wraps, no trap
    alu2(ALU_ADDU, 32'h7FFF_FFFF, 32'd1); step();
    chk("addu_ovf", alu_out, 32'h8000_0000);

    // debug word on A, immediate on B, rt forwarded from WB to dm_wdata
    alu2(ALU_ADDU, 32'd0, 32'd0);
    fwd_sel0 = FWD_DBG; b_sel = 1'b1; imm32 = 32'd1;
    fwd_sel1 = FWD_WB; bypass_wb = 32'hCAFE_0001;
    step();
    chk("dbg_imm",  alu_out, 32'h1234_ABCE);
    chk("wdata_wb", dm_wdata, 32'hCAFE_0001);

    alu2(ALU_SRA, 32'd0, 32'h8000_0000); shamt = 5'd4; step();
    chk("sra", alu_out, 32'hF800_0000);
    alu2(ALU_SRL, 32'd0, 32'h8000_0000); shamt = 5'd4; step();
    chk("srl", alu_out, 32'h0800_0000);
    alu2(ALU_SLTU, 32'hFFFF_FFFF, 32'd1); step();
    chk("sltu", alu_out, 32'd0);
    alu2(ALU_SLT, 32'hFFFF_FFFF, 32'd1); step();
    chk("slt", alu_out, 32'd1);
    alu2(ALU_SLLV, 32'd36, 32'd1); step();
    chk("sllv", alu_out, 32'h10);
    alu2(ALU_SUBU, 32'd3, 32'd5); step();
    chk("subu", alu_out, 32'hFFFF_FFFE);
    alu2(ALU_NOR, 32'h0F0F_0000, 32'h0000_00F0); step();
    chk("nor", alu_out, 32'hF0F0_FF0F);
    alu2(ALU_LUI, 32'd0, 32'd0); b_sel = 1'b1; imm32 = 32'h0000_1234; step();
    chk("lui", alu_out, 32'h1234_0000);
    alu2(ALU_LINK, 32'd0, 32'd0); pc_in = 32'h0000_3010; step();
    chk("link", alu_out, 32'h0000_3018);
    alu2(5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF); step();
    chk("unused_op", alu_out, 32'd0);

`ifdef EX_MDU_EN
    // mult -3 * 7
    alu2(ALU_ADDU, 32'hFFFF_FFFD, 32'd7); md_op = MD_MULT; #1;
    chk("mult_busy_pre", md_busy, 1);
    step(); idle_in();
    for (int k = 0; k < 5; k++) begin
      #1; chk($sformatf("mult_busy_%0d", k), md_busy, 1);
      step();
    end
    chk("mult_done", md_busy, 0);
    alu_op = ALU_MFLO; step();
    chk("mult_lo", alu_out, 32'hFFFF_FFEB);
    alu_op = ALU_MFHI; step();
    chk("mult_hi", alu_out, 32'hFFFF_FFFF);

    // div -7 / 2
    alu2(ALU_ADDU, 32'hFFFF_FFF9, 32'd2); md_op = MD_DIV; step(); idle_in();
    for (int k = 0; k < 10; k++) begin
      #1; chk($sformatf("div_busy_%0d", k), md_busy, 1);
      step();
    end
    chk("div_done", md_busy, 0);
    alu_op = ALU_MFLO; step();
    chk("div_lo", alu_out, 32'hFFFF_FFFD);
    alu_op = ALU_MFHI; step();
    chk("div_hi", alu_out, 32'hFFFF_FFFF);

    // divu by zero leaves HI/LO alone but still runs the full busy time
    alu2(ALU_ADDU, 32'd5, 32'd0); md_op = MD_DIVU; step(); idle_in();
    for (int k = 0; k < 9; k++) step();
    #1; chk("divz_busy_last", md_busy, 1);
    step();
    chk("divz_done", md_busy, 0);
    alu_op = ALU_MFLO; step();
    chk("divz_lo", alu_out, 32'hFFFF_FFFD);
    alu_op = ALU_MFHI; step();
    chk("divz_hi", alu_out, 32'hFFFF_FFFF);

    // mtlo writes LO at the next edge
    alu2(ALU_ADDU, 32'h0000_ABCD, 32'd0); md_op = MD_MTLO; step(); idle_in();
    alu_op = ALU_MFLO; step();
    chk("mtlo", alu_out, 32'h0000_ABCD);

    // reset three cycles into a div
    alu2(ALU_ADDU, 32'd100, 32'd3); md_op = MD_DIV; step(); idle_in();
    step(); step(); step();
    reset = 1'b1; step(); reset = 1'b0;
    chk("rst_div_busy", md_busy, 0);
    alu_op = ALU_MFLO; step();
    chk("rst_div_lo", alu_out, 32'd0);
    alu_op = ALU_MFHI; step();
    chk("rst_div_hi", alu_out, 32'd0);
`else
    // without the MDU, md_op is ignored and HI/LO read as 0
    alu2(ALU_ADDU, 32'hFFFF_FFFD, 32'd7); md_op = MD_MULT; #1;
    chk("nomdu_busy", md_busy, 0);
    step(); idle_in();
    for (int k = 0; k < 6; k++) step();
    alu_op = ALU_MFLO; step();
    chk("nomdu_lo", alu_out, 32'd0);
    alu2(ALU_ADDU, 32'h0000_ABCD, 32'd0); md_op = MD_MTHI; step(); idle_in();
    alu_op = ALU_MFHI; step();
    chk("nomdu_hi", alu_out, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
